// File: rtl/seg7_scan_decoder_pkg.sv
// Segment pattern table shared by the 7-segment encoder and this scan decoder.
// Patterns are active-low: bit6=a ... bit0=g.
package seg7_scan_decoder_pkg;

  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef struct packed {
    logic [3:0] value;
    logic       err;
  } dec_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Strobed segment input and committed-digit readback of the scan decoder.
// master drives the scan side; slave is the decoder.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2
);
  logic [6:0]              seg_in;
  logic [IDX_W-1:0]        dig_idx;
  logic                    seg_stb;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   err_mask;
  logic                    frame_vld;

  modport master (
    output seg_in, dig_idx, seg_stb,
    input  bcd_out, err_mask, frame_vld
  );

  modport slave (
    input  seg_in, dig_idx, seg_stb,
    output bcd_out, err_mask, frame_vld
  );
endinterface

// File: rtl/seg7_scan_decoder_to_bcd.sv
// Combinational active-low segment pattern -> {BCD value, illegal flag}.
// Blank decodes to BCD_BLANK without error; anything unlisted is BCD_BLANK with error.
module seg7_to_bcd
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output dec_t       dec_o
);
  always_comb begin
    dec_o = '{value: BCD_BLANK, err: 1'b1};
    case (seg_i)
      SEG_0:     dec_o = '{value: 4'd0, err: 1'b0};
      SEG_1:     dec_o = '{value: 4'd1, err: 1'b0};
      SEG_2:     dec_o = '{value: 4'd2, err: 1'b0};
      SEG_3:     dec_o = '{value: 4'd3, err: 1'b0};
      SEG_4:     dec_o = '{value: 4'd4, err: 1'b0};
      SEG_5:     dec_o = '{value: 4'd5, err: 1'b0};
      SEG_6:     dec_o = '{value: 4'd6, err: 1'b0};
      SEG_7:     dec_o = '{value: 4'd7, err: 1'b0};
      SEG_8:     dec_o = '{value: 4'd8, err: 1'b0};
      SEG_9:     dec_o = '{value: 4'd9, err: 1'b0};
      SEG_BLANK: dec_o = '{value: BCD_BLANK, err: 1'b0};
      default:   dec_o = '{value: BCD_BLANK, err: 1'b1};
    endcase
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// Decodes time-multiplexed 7-segment strobes to BCD with a per-digit stability filter.
// Strobe to bcd_out/frame_vld is two clocks; accepts one strobe per clock, no backpressure.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2,
  parameter int STABLE_CNT = 3
) (
  input  logic                clk,
  input  logic                resett,
  seg7_scan_decoder_if.slave  bus
);
  localparam logic [3:0]       CNT_MAX  = 4'(STABLE_CNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  dec_t             dec;
  logic             in_range;

  logic             s1_vld_q, s1_vld_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  dec_t             s1_dec_q, s1_dec_d;

  dec_t             cand_q [NUM_DIGITS];
  dec_t             cand_d [NUM_DIGITS];
  logic [3:0]       cnt_q  [NUM_DIGITS];
  logic [3:0]       cnt_d  [NUM_DIGITS];
  dec_t             out_q  [NUM_DIGITS];
  dec_t             out_d  [NUM_DIGITS];
  logic             dirty_q, dirty_d;
  logic             frame_q, frame_d;

  logic [3:0]       cnt_nx;
  logic             changed;

  logic [4*NUM_DIGITS-1:0] bcd_pk;
  logic [NUM_DIGITS-1:0]   err_pk;

  seg7_to_bcd u_to_bcd (
    .seg_i (bus.seg_in),
    .dec_o (dec)
  );

  assign in_range = 32'(bus.dig_idx) < NUM_DIGITS;

  always_comb begin
    s1_vld_d = bus.seg_stb & in_range;
    s1_idx_d = s1_idx_q;
    s1_dec_d = s1_dec_q;
    if (s1_vld_d) begin
      s1_idx_d = bus.dig_idx;
      s1_dec_d = dec;
    end
  end

  // Count is the length of the current run of identical decodes, capped at CNT_MAX.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    dirty_d = dirty_q;
    frame_d = 1'b0;
    cnt_nx  = '0;
    changed = 1'b0;
    if (s1_vld_q) begin
      if (s1_dec_q == cand_q[s1_idx_q]) begin
        cnt_nx = (cnt_q[s1_idx_q] == CNT_MAX) ? CNT_MAX : cnt_q[s1_idx_q] + 4'd1;
      end else begin
        cand_d[s1_idx_q] = s1_dec_q;
        cnt_nx           = 4'd1;
      end
      cnt_d[s1_idx_q] = cnt_nx;
      if (cnt_nx == CNT_MAX) begin
        out_d[s1_idx_q] = s1_dec_q;
        changed         = (s1_dec_q != out_q[s1_idx_q]);
      end
      if (s1_idx_q == LAST_IDX) begin
        frame_d = dirty_q | changed;
        dirty_d = 1'b0;
      end else begin
        dirty_d = dirty_q | changed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resett) begin
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
      s1_dec_q <= '0;
      dirty_q  <= 1'b0;
      frame_q  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand_q[i] <= '0;
        cnt_q[i]  <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_idx_q <= s1_idx_d;
      s1_dec_q <= s1_dec_d;
      dirty_q  <= dirty_d;
      frame_q  <= frame_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    bcd_pk = '0;
    err_pk = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_pk[4*i +: 4] = out_q[i].value;
      err_pk[i]        = out_q[i].err;
    end
  end

  assign bus.bcd_out   = bcd_pk;
  assign bus.err_mask  = err_pk;
  assign bus.frame_vld = frame_q;

endmodule
